// File: rtl/change_dispenser.sv
// change_dispenser: pays a cents amount out of the coin hopper as one eject
// pulse per coin, largest coin first, limited by per-coin inventory counters.
// Each coin is confirmed by hopper_ack; a missing ack ends the payout with fault.
module change_dispenser #(
  parameter int PULSE_CYC = 10,
  parameter int GAP_CYC   = 5,
  parameter int ACK_TO    = 50,
  parameter int INV_W     = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       amount,
  input  logic             inv_load,
  input  logic [INV_W-1:0] inv_d,
  input  logic [INV_W-1:0] inv_q,
  input  logic [INV_W-1:0] inv_i,
  input  logic [INV_W-1:0] inv_n,
  input  logic             hopper_ack,
  output logic             D_o,
  output logic             Q_o,
  output logic             I_o,
  output logic             N_o,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic [7:0]       short_amt
);

  typedef enum logic [2:0] {IDLE, SELECT, PULSE, WAIT_ACK, GAP, DONE} state_t;
  typedef enum logic [1:0] {COIN_D, COIN_Q, COIN_I, COIN_N} coin_t;

  localparam logic [7:0]       PULSE_LAST = 8'(PULSE_CYC - 1);
  localparam logic [7:0]       GAP_LAST   = 8'(GAP_CYC - 1);
  localparam logic [7:0]       ACK_LAST   = 8'(ACK_TO - 1);
  localparam logic [INV_W-1:0] INV_ONE    = INV_W'(1);

  state_t           state;
  state_t           next_state;
  coin_t            coin;
  coin_t            pick;
  coin_t            line_coin;
  logic             pick_ok;
  logic [7:0]       rem;
  logic [7:0]       coin_val;
  logic [7:0]       cyc;
  logic [INV_W-1:0] cnt_d;
  logic [INV_W-1:0] cnt_q;
  logic [INV_W-1:0] cnt_i;
  logic [INV_W-1:0] cnt_n;

  // Greedy choice: first coin that still fits in rem and is in stock.
  always_comb begin
    pick    = COIN_N;
    pick_ok = 1'b1;
    if (rem >= 8'd100 && cnt_d != '0)      pick = COIN_D;
    else if (rem >= 8'd25 && cnt_q != '0)  pick = COIN_Q;
    else if (rem >= 8'd10 && cnt_i != '0)  pick = COIN_I;
    else if (rem >= 8'd5 && cnt_n != '0)   pick = COIN_N;
    else                                   pick_ok = 1'b0;
  end

  // Value in cents of the latched coin, used when its ack arrives.
  always_comb begin
    coin_val = 8'd5;
    case (coin)
      COIN_D:  coin_val = 8'd100;
      COIN_Q:  coin_val = 8'd25;
      COIN_I:  coin_val = 8'd10;
      default: coin_val = 8'd5;
    endcase
  end

  // The coin driving the eject line next cycle: fresh pick on entry to PULSE.
  assign line_coin = (state == SELECT) ? pick : coin;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Next-state logic; rem==0 yields no pick, so it falls through to DONE too.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (start) next_state = SELECT;
      SELECT:   next_state = pick_ok ? PULSE : DONE;
      PULSE:    if (cyc == PULSE_LAST) next_state = WAIT_ACK;
      WAIT_ACK: begin
        if (hopper_ack)            next_state = GAP;
        else if (cyc == ACK_LAST)  next_state = DONE;
      end
      GAP:      if (cyc == GAP_LAST) next_state = SELECT;
      DONE:     next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Datapath and registered outputs, all derived from the upcoming state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      coin      <= COIN_N;
      rem       <= '0;
      cyc       <= '0;
      cnt_d     <= '0;
      cnt_q     <= '0;
      cnt_i     <= '0;
      cnt_n     <= '0;
      D_o       <= 1'b0;
      Q_o       <= 1'b0;
      I_o       <= 1'b0;
      N_o       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fault     <= 1'b0;
      short_amt <= '0;
    end else begin
      cyc  <= (next_state != state || state == IDLE) ? 8'd0 : cyc + 8'd1;
      busy <= (next_state != IDLE);
      done <= (next_state == DONE);
      D_o  <= (next_state == PULSE) && (line_coin == COIN_D);
      Q_o  <= (next_state == PULSE) && (line_coin == COIN_Q);
      I_o  <= (next_state == PULSE) && (line_coin == COIN_I);
      N_o  <= (next_state == PULSE) && (line_coin == COIN_N);

      if (state == IDLE) begin
        if (start) begin
          rem       <= amount - (amount % 8'd5);
          fault     <= 1'b0;
          short_amt <= '0;
        end
        if (inv_load) begin
          cnt_d <= inv_d;
          cnt_q <= inv_q;
          cnt_i <= inv_i;
          cnt_n <= inv_n;
        end
      end

      if (state == SELECT && pick_ok) coin <= pick;

      if (state == WAIT_ACK) begin
        if (hopper_ack) begin
          rem <= rem - coin_val;
          case (coin)
            COIN_D:  cnt_d <= cnt_d - INV_ONE;
            COIN_Q:  cnt_q <= cnt_q - INV_ONE;
            COIN_I:  cnt_i <= cnt_i - INV_ONE;
            default: cnt_n <= cnt_n - INV_ONE;
          endcase
        end else if (cyc == ACK_LAST) begin
          fault <= 1'b1;
        end
      end

      if (next_state == DONE) short_amt <= rem;
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: table-driven payouts plus hand-written corner cases.
// Expected coins go into a queue when a payout is started; a monitor pops
// and compares them as each eject pulse ends, and drives hopper_ack.
module tb_change_dispenser;

  localparam int PULSE_CYC = 10;
  localparam int GAP_CYC   = 5;
  localparam int ACK_TO    = 50;

  localparam logic [3:0] C_D = 4'b1000;
  localparam logic [3:0] C_Q = 4'b0100;
  localparam logic [3:0] C_I = 4'b0010;
  localparam logic [3:0] C_N = 4'b0001;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] amount;
  logic       inv_load;
  logic [5:0] inv_d, inv_q, inv_i, inv_n;
  logic       hopper_ack;
  logic       D_o, Q_o, I_o, N_o, busy, done, fault;
  logic [7:0] short_amt;
  logic [3:0] lines;

  int total = 0;
  int bad   = 0;
  logic [3:0] exp_q[$];
  int   ack_delay = 1;
  logic ack_on    = 1'b1;
  event coin_fell;

  typedef struct {
    logic       load;
    logic [5:0] d, q, i, n;
    logic [7:0] amt;
    int         ack;
    int         nd, nq, ni, nn;
    int         short_exp;
  } vec_t;

  vec_t vecs[10];

  always #5 clk = ~clk;

  assign lines = {D_o, Q_o, I_o, N_o};

  change_dispenser #(
    .PULSE_CYC(PULSE_CYC), .GAP_CYC(GAP_CYC), .ACK_TO(ACK_TO), .INV_W(6)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .amount(amount), .inv_load(inv_load),
    .inv_d(inv_d), .inv_q(inv_q), .inv_i(inv_i), .inv_n(inv_n),
    .hopper_ack(hopper_ack),
    .D_o(D_o), .Q_o(Q_o), .I_o(I_o), .N_o(N_o),
    .busy(busy), .done(done), .fault(fault), .short_amt(short_amt)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic pushCoins(input int nd, input int nq, input int ni, input int nn);
    for (int k = 0; k < nd; k++) exp_q.push_back(C_D);
    for (int k = 0; k < nq; k++) exp_q.push_back(C_Q);
    for (int k = 0; k < ni; k++) exp_q.push_back(C_I);
    for (int k = 0; k < nn; k++) exp_q.push_back(C_N);
  endtask

  // Drives start (and optional inventory load) at a negedge; returns one
  // negedge later, just after the accepting edge.
  task automatic applyStimulus(input logic load, input logic [5:0] d, input logic [5:0] q,
                               input logic [5:0] i, input logic [5:0] n,
                               input logic [7:0] amt);
    inv_load = load;
    inv_d = d; inv_q = q; inv_i = i; inv_n = n;
    amount = amt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    inv_load = 1'b0;
    checkOutput("busy_on_start", busy, 1);
  endtask

  // Waits (bounded) for done; cnt counts negedges since start was driven.
  task automatic waitDone(input int start_cnt, input int exp_cnt,
                          input int exp_short, input int exp_fault);
    int cnt;
    cnt = start_cnt;
    while (done !== 1'b1 && cnt < 2000) begin
      @(negedge clk);
      cnt++;
    end
    checkOutput("done_cycle", cnt, exp_cnt);
    checkOutput("short_amt", short_amt, exp_short);
    checkOutput("fault", fault, exp_fault);
    checkOutput("coins_left", exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk);
    checkOutput("done_width", done, 0);
    checkOutput("busy_after", busy, 0);
  endtask

  // Coin monitor: on each falling eject line, compare coin and pulse length.
  initial begin
    logic [3:0] prev;
    int len;
    prev = '0;
    len = 0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        prev = '0;
        len = 0;
      end else begin
        if (lines != 4'b0000) begin
          len++;
        end else if (prev != 4'b0000) begin
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_coin", prev, 0);
          end else begin
            checkOutput("coin_type", prev, exp_q.pop_front());
          end
          checkOutput("pulse_len", len, PULSE_CYC);
          len = 0;
          ->coin_fell;
        end
        prev = lines;
      end
    end
  end

  // Hopper model: acknowledges each coin ack_delay cycles into WAIT_ACK.
  initial begin
    hopper_ack = 1'b0;
    forever begin
      @(coin_fell);
      if (ack_on) begin
        repeat (ack_delay - 1) @(negedge clk);
        hopper_ack = 1'b1;
        @(negedge clk);
        hopper_ack = 1'b0;
      end
    end
  end

  initial begin
    int cnt;
    vecs[0] = '{1'b1, 6'd10, 6'd10, 6'd10, 6'd10, 8'd70,  2,  0, 2, 2, 0, 0};
    vecs[1] = '{1'b0, 6'd0,  6'd0,  6'd0,  6'd0,  8'd255, 1,  2, 2, 0, 1, 0};
    vecs[2] = '{1'b1, 6'd0,  6'd0,  6'd3,  6'd5,  8'd85,  3,  0, 0, 3, 5, 30};
    vecs[3] = '{1'b0, 6'd0,  6'd0,  6'd0,  6'd0,  8'd10,  1,  0, 0, 0, 0, 10};
    vecs[4] = '{1'b1, 6'd10, 6'd10, 6'd10, 6'd10, 8'd73,  2,  0, 2, 2, 0, 0};
    vecs[5] = '{1'b0, 6'd0,  6'd0,  6'd0,  6'd0,  8'd0,   1,  0, 0, 0, 0, 0};
    vecs[6] = '{1'b0, 6'd0,  6'd0,  6'd0,  6'd0,  8'd4,   1,  0, 0, 0, 0, 0};
    vecs[7] = '{1'b1, 6'd63, 6'd63, 6'd63, 6'd63, 8'd200, 50, 2, 0, 0, 0, 0};
    vecs[8] = '{1'b1, 6'd1,  6'd1,  6'd1,  6'd1,  8'd255, 1,  1, 1, 1, 1, 115};
    vecs[9] = '{1'b0, 6'd0,  6'd0,  6'd0,  6'd0,  8'd5,   1,  0, 0, 0, 0, 5};

    rst = 1'b0; start = 1'b0; inv_load = 1'b0; amount = '0;
    inv_d = '0; inv_q = '0; inv_i = '0; inv_n = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_lines", lines, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_fault", fault, 0);
    checkOutput("rst_short", short_amt, 0);
    rst = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 10; v++) begin
      int ncoin;
      ncoin = vecs[v].nd + vecs[v].nq + vecs[v].ni + vecs[v].nn;
      ack_delay = vecs[v].ack;
      pushCoins(vecs[v].nd, vecs[v].nq, vecs[v].ni, vecs[v].nn);
      applyStimulus(vecs[v].load, vecs[v].d, vecs[v].q, vecs[v].i, vecs[v].n, vecs[v].amt);
      waitDone(1, 2 + ncoin * (1 + PULSE_CYC + vecs[v].ack + GAP_CYC), vecs[v].short_exp, 0);
    end

    // Ack timeout: one Q pulse, no ack, fault after ACK_TO cycles.
    $display("[TB] ack timeout");
    ack_on = 1'b0;
    pushCoins(0, 1, 0, 0);
    applyStimulus(1'b1, 6'd10, 6'd10, 6'd10, 6'd10, 8'd25);
    waitDone(1, 2 + PULSE_CYC + ACK_TO, 25, 1);
    ack_on = 1'b1;
    ack_delay = 2;
    pushCoins(0, 1, 0, 0);
    applyStimulus(1'b0, 6'd0, 6'd0, 6'd0, 6'd0, 8'd25);
    waitDone(1, 2 + 18, 0, 0);

    // start/inv_load during a D pulse must be ignored.
    $display("[TB] inputs ignored while busy");
    pushCoins(1, 0, 0, 0);
    applyStimulus(1'b1, 6'd10, 6'd10, 6'd10, 6'd10, 8'd100);
    repeat (4) @(negedge clk);
    start = 1'b1; amount = 8'd25; inv_load = 1'b1;
    inv_d = '0; inv_q = '0; inv_i = '0; inv_n = '0;
    @(negedge clk);
    start = 1'b0; inv_load = 1'b0;
    waitDone(6, 2 + 18, 0, 0);
    pushCoins(1, 0, 0, 0);
    applyStimulus(1'b0, 6'd0, 6'd0, 6'd0, 6'd0, 8'd100);
    waitDone(1, 2 + 18, 0, 0);

    // Async reset during the third cycle of a Q pulse.
    $display("[TB] reset mid-pulse");
    pushCoins(0, 1, 0, 0);
    applyStimulus(1'b1, 6'd10, 6'd10, 6'd10, 6'd10, 8'd25);
    cnt = 0;
    while (Q_o !== 1'b1 && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    checkOutput("q_rise", Q_o, 1);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checkOutput("rst_q_drop", Q_o, 0);
    checkOutput("rst_busy_drop", busy, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    applyStimulus(1'b0, 6'd0, 6'd0, 6'd0, 6'd0, 8'd5);
    waitDone(1, 2, 5, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
